// File: rtl/axi_wline_master.sv
// Writes one 16-byte line as a single 4-beat INCR AXI write burst, then pulses done_o.
// Optional: define AXI_WLINE_BRESP_CHECK_EN to flag non-OKAY write responses on err_o.
module axi_wline_master #(
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen_i,
    input  logic [31:0]  waddr_i,
    input  logic [127:0] wdata_i,
    output logic         done_o,
    output logic         busy_o,
    output logic         err_o,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);
    localparam int unsigned WORD_W    = 32;
    localparam logic [1:0]  LAST_BEAT = 2'd3;

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_e;

    state_e       state_q;
    logic [127:0] line_q;
    logic [1:0]   beat_q;
    logic [1:0]   beat_nxt_c;
    logic [31:0]  next_word_c;
    logic         unused_ok;

    assign beat_nxt_c  = beat_q + 2'd1;
    assign next_word_c = line_q[{beat_nxt_c, 5'b0} +: WORD_W];

    // Outputs are computed for the state being entered, so every AXI valid/ready is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            beat_q  <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
            awid    <= '0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            awburst <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wlast   <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wen_i) begin
                        line_q  <= wdata_i;
                        awaddr  <= {waddr_i[31:4], 4'b0000};
                        awid    <= AXI_ID;
                        awlen   <= 8'd3;
                        awsize  <= 3'b010;
                        awburst <= 2'b01;
                        awvalid <= 1'b1;
                        busy_o  <= 1'b1;
                        state_q <= AW;
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wstrb   <= 4'hF;
                        wdata   <= line_q[WORD_W-1:0];
                        wlast   <= 1'b0;
                        beat_q  <= 2'd0;
                        state_q <= W;
                    end
                end
                W: begin
                    if (wready) begin
                        beat_q <= beat_nxt_c;
                        if (beat_q == LAST_BEAT) begin
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            wstrb   <= 4'h0;
                            bready  <= 1'b1;
                            state_q <= B;
                        end else begin
                            wdata <= next_word_c;
                            wlast <= (beat_nxt_c == LAST_BEAT);
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI_WLINE_BRESP_CHECK_EN
    // Sticky until reset; any non-OKAY response on the B handshake sets it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (state_q == B && bvalid && bresp != 2'b00) begin
            err_o <= 1'b1;
        end
    end
    assign unused_ok = ^bid;
`else
    assign err_o     = 1'b0;
    assign unused_ok = ^{bid, bresp};
`endif

endmodule

// File: tb/tb_axi_wline_master.sv
// Self-checking bench for axi_wline_master: randomized slave timing against a line-level reference model.
`timescale 1ns/1ps
module tb_axi_wline_master;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wen_i = 1'b0;
    logic [31:0]  waddr_i = '0;
    logic [127:0] wdata_i = '0;
    logic         done_o, busy_o, err_o;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid;
    logic         wready = 1'b0;
    logic [3:0]   bid = '0;
    logic [1:0]   bresp = '0;
    logic         bvalid = 1'b0;
    logic         bready;

    axi_wline_master dut (
        .clk(clk), .rst(rst), .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

`ifdef AXI_WLINE_BRESP_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // Per-line stimulus: address, data and slave wait profile.
    logic [31:0]  la[8];
    logic [127:0] ld[8];
    int           aw_w[8], ws_beat[8], ws_len[8], b_w[8];
    logic [1:0]   br[8];

    // Per-line observations.
    logic [31:0]  o_awaddr[8];
    logic [16:0]  o_awctl[8];
    int           acc_c[8], done_c[8], nbeats[8], aw_vcyc[8];
    logic [31:0]  q_data[$];
    logic         q_last[$];
    logic [3:0]   q_strb[$];
    int           aw_unstable, early_w, stall_bad, extra_done, n_acc, n_done;
    logic         tmo;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:4], 4'h0};
    endfunction

    function automatic int exp_occ(input int i);
        return 7 + aw_w[i] + ((ws_beat[i] < 4) ? ws_len[i] : 0) + b_w[i];
    endfunction

    task automatic set_line(input int i, input logic [31:0] a, input logic [127:0] d, input int aw,
                            input int sb, input int sl, input int bw, input logic [1:0] r);
        la[i] = a; ld[i] = d; aw_w[i] = aw; ws_beat[i] = sb; ws_len[i] = sl; b_w[i] = bw; br[i] = r;
    endtask

    // Acts as the AXI slave and write buffer for n lines; wen_i stays high while lines remain.
    task automatic run_lines(input int n);
        int cur, aw_cnt, st_cnt, b_cnt, wbeat;
        logic prev_busy, aw_seen, aw_granted;
        logic [31:0] aw_first;
        logic [127:0] dcur;
        q_data.delete(); q_last.delete(); q_strb.delete();
        aw_unstable = 0; early_w = 0; stall_bad = 0; extra_done = 0; n_acc = 0; n_done = 0;
        cur = 0; aw_cnt = 0; st_cnt = 0; b_cnt = 0; wbeat = 0; aw_seen = 0; aw_granted = 0; aw_first = '0;
        for (int i = 0; i < 8; i++) begin nbeats[i] = 0; aw_vcyc[i] = 0; end
        @(negedge clk);
        wen_i = 1'b1; waddr_i = la[0]; wdata_i = ld[0];
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        prev_busy = busy_o;
        for (int t = 0; t < 600 && n_done < n; t++) begin
            @(negedge clk);
            if (busy_o && !prev_busy && n_acc < n) begin
                cur = n_acc; acc_c[cur] = cyc - 1; n_acc++;
                aw_cnt = 0; st_cnt = 0; b_cnt = 0; wbeat = 0; aw_seen = 0; aw_granted = 0;
                if (n_acc < n) begin
                    waddr_i = la[n_acc]; wdata_i = ld[n_acc];
                end else begin
                    wen_i = 1'b0; waddr_i = $urandom; wdata_i = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            prev_busy = busy_o;
            dcur = ld[cur];
            wready = 1'b0;
            if (wvalid) begin
                if (!aw_granted || awvalid) early_w++;
                if (wbeat == ws_beat[cur] && st_cnt < ws_len[cur]) begin
                    if (wdata !== dcur[wbeat*32 +: 32] || wlast !== (wbeat == 3)) stall_bad++;
                    st_cnt++;
                end else begin
                    wready = 1'b1;
                    q_data.push_back(wdata); q_last.push_back(wlast); q_strb.push_back(wstrb);
                    wbeat++; nbeats[cur] = wbeat;
                end
            end
            awready = 1'b0;
            if (awvalid) begin
                if (aw_seen && awaddr !== aw_first) aw_unstable++;
                if (!aw_seen) begin aw_first = awaddr; aw_seen = 1'b1; end
                aw_vcyc[cur]++;
                if (aw_cnt >= aw_w[cur]) begin
                    awready = 1'b1; aw_granted = 1'b1;
                    o_awaddr[cur] = awaddr;
                    o_awctl[cur] = {awid, awlen, awsize, awburst};
                end
                aw_cnt++;
            end
            bvalid = 1'b0;
            bresp = 2'($urandom);
            if (bready) begin
                if (b_cnt >= b_w[cur]) begin bvalid = 1'b1; bresp = br[cur]; bid = 4'($urandom); end
                b_cnt++;
            end
            if (done_o) begin
                if (n_done < 8) done_c[n_done] = cyc;
                n_done++;
            end
        end
        tmo = (n_done < n);
        wen_i = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done_o) extra_done++;
        end
    endtask

    task automatic test_reset();
        logic [91:0] outs;
        rst = 1'b0; wen_i = 1'b1; waddr_i = $urandom; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        repeat (3) @(negedge clk);
        outs = {done_o, busy_o, err_o, awid, awaddr, awlen, awsize, awburst, awvalid,
                wdata, wstrb, wlast, wvalid, bready};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        wen_i = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_basic();
        logic [31:0] expw[4];
        expw[0] = 32'h11111111; expw[1] = 32'h22222222; expw[2] = 32'h33333333; expw[3] = 32'h44444444;
        set_line(0, 32'h1000_0004, 128'h44444444_33333333_22222222_11111111, 0, 4, 0, 0, 2'b00);
        run_lines(1);
        total++;
        if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout: done count %0d want 1", n_done); end
        total++;
        if (o_awaddr[0] !== 32'h1000_0000) begin bad++; $display("FAIL basic_awaddr: got %h want 10000000", o_awaddr[0]); end
        total++;
        if (o_awctl[0] !== {4'h1, 8'd3, 3'b010, 2'b01}) begin
            bad++; $display("FAIL basic_awctl: got %h want %h", o_awctl[0], {4'h1, 8'd3, 3'b010, 2'b01});
        end
        total++;
        if (q_data.size() !== 4) begin bad++; $display("FAIL basic_beats: got %0d want 4", q_data.size()); end
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            total++;
            if ({q_data[k], q_last[k], q_strb[k]} !== {expw[k], k == 3, 4'hF}) begin
                bad++; $display("FAIL basic_beat%0d: got %h/%b/%h want %h/%b/f", k, q_data[k], q_last[k], q_strb[k], expw[k], k == 3);
            end
        end
        total++;
        if (done_c[0] - acc_c[0] !== 7) begin bad++; $display("FAIL basic_latency: got %0d want 7", done_c[0] - acc_c[0]); end
        total++;
        if (extra_done !== 0 || early_w !== 0) begin
            bad++; $display("FAIL basic_protocol: extra_done %0d early_w %0d want 0 0", extra_done, early_w);
        end
    endtask

    task automatic test_aw_stall();
        set_line(0, 32'hABCD_123C, {$urandom, $urandom, $urandom, $urandom}, 5, 4, 0, 0, 2'b00);
        run_lines(1);
        total++;
        if (tmo !== 1'b0) begin bad++; $display("FAIL awstall_timeout: done count %0d want 1", n_done); end
        total++;
        if (aw_vcyc[0] !== 6 || aw_unstable !== 0) begin
            bad++; $display("FAIL awstall_hold: awvalid cycles %0d unstable %0d want 6 0", aw_vcyc[0], aw_unstable);
        end
        total++;
        if (early_w !== 0) begin bad++; $display("FAIL awstall_early_w: got %0d want 0", early_w); end
        total++;
        if (o_awaddr[0] !== 32'hABCD_1230) begin bad++; $display("FAIL awstall_awaddr: got %h want abcd1230", o_awaddr[0]); end
        total++;
        if (done_c[0] - acc_c[0] !== exp_occ(0)) begin
            bad++; $display("FAIL awstall_latency: got %0d want %0d", done_c[0] - acc_c[0], exp_occ(0));
        end
    endtask

    task automatic test_w_stall();
        set_line(0, 32'h1000_0004, 128'h44444444_33333333_22222222_11111111, 0, 2, 3, 0, 2'b00);
        run_lines(1);
        total++;
        if (stall_bad !== 0) begin bad++; $display("FAIL wstall_hold: bad stall cycles %0d want 0", stall_bad); end
        total++;
        if (q_data.size() !== 4 || nbeats[0] !== 4) begin
            bad++; $display("FAIL wstall_count: got %0d want 4", q_data.size());
        end
        total++;
        if (q_data.size() == 4 && q_data[2] !== 32'h33333333) begin
            bad++; $display("FAIL wstall_beat2: got %h want 33333333", q_data[2]);
        end
        total++;
        if (done_c[0] - acc_c[0] !== 10) begin bad++; $display("FAIL wstall_latency: got %0d want 10", done_c[0] - acc_c[0]); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        for (int i = 0; i < 3; i++)
            set_line(i, $urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 4, 0, 0, 2'b00);
        run_lines(3);
        total++;
        if (tmo !== 1'b0 || extra_done !== 0) begin
            bad++; $display("FAIL b2b_done_count: got %0d+%0d want 3+0", n_done, extra_done);
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (acc_c[i] !== done_c[i-1] + 1) begin
                bad++; $display("FAIL b2b_accept%0d: got cycle %0d want %0d", i, acc_c[i], done_c[i-1] + 1);
            end
        end
        total++;
        if (q_data.size() !== 12) begin bad++; $display("FAIL b2b_beats: got %0d want 12", q_data.size()); end
        for (int i = 0; i < 3; i++) begin
            d = ld[i];
            total++;
            if (o_awaddr[i] !== line_addr(la[i]) || (q_data.size() == 12 && q_data[i*4+3] !== d[127:96])) begin
                bad++; $display("FAIL b2b_line%0d: awaddr %h want %h", i, o_awaddr[i], line_addr(la[i]));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [91:0] outs;
        int dn;
        @(negedge clk);
        wen_i = 1'b1; waddr_i = 32'h2000_0008; wdata_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        @(negedge clk);
        wen_i = 1'b0; awready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b1;
        @(negedge clk);
        total++;
        if (wdata !== 32'hBBBBBBBB) begin bad++; $display("FAIL midrst_beat1: got %h want bbbbbbbb", wdata); end
        rst = 1'b0;
        @(negedge clk);
        outs = {done_o, busy_o, err_o, awid, awaddr, awlen, awsize, awburst, awvalid,
                wdata, wstrb, wlast, wvalid, bready};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL midrst_outputs: got %h want 0", outs); end
        rst = 1'b1; wready = 1'b0; bvalid = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        bvalid = 1'b0;
        total++;
        if (dn !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", dn); end
        set_line(0, 32'h3000_00F0, {$urandom, $urandom, $urandom, $urandom}, 1, 4, 0, 1, 2'b00);
        run_lines(1);
        total++;
        if (tmo !== 1'b0 || q_data.size() !== 4 || done_c[0] - acc_c[0] !== exp_occ(0)) begin
            bad++; $display("FAIL midrst_recover: done %0d beats %0d latency %0d want 1 4 %0d",
                            n_done, q_data.size(), done_c[0] - acc_c[0], exp_occ(0));
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        int idx;
        for (int i = 0; i < 6; i++)
            set_line(i, $urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(1, 3), $urandom_range(0, 3), 2'b00);
        run_lines(6);
        total++;
        if (tmo !== 1'b0 || extra_done !== 0) begin
            bad++; $display("FAIL rand_done_count: got %0d+%0d want 6+0", n_done, extra_done);
        end
        total++;
        if (early_w !== 0 || aw_unstable !== 0 || stall_bad !== 0) begin
            bad++; $display("FAIL rand_protocol: early_w %0d aw_unstable %0d stall_bad %0d want 0 0 0",
                            early_w, aw_unstable, stall_bad);
        end
        total++;
        if (q_data.size() !== 24) begin bad++; $display("FAIL rand_beats: got %0d want 24", q_data.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({o_awaddr[i], o_awctl[i]} !== {line_addr(la[i]), 4'h1, 8'd3, 3'b010, 2'b01}) begin
                bad++; $display("FAIL rand_aw%0d: got %h/%h want %h", i, o_awaddr[i], o_awctl[i], line_addr(la[i]));
            end
            total++;
            if (done_c[i] - acc_c[i] !== exp_occ(i)) begin
                bad++; $display("FAIL rand_latency%0d: got %0d want %0d", i, done_c[i] - acc_c[i], exp_occ(i));
            end
            d = ld[i];
            for (int k = 0; k < 4; k++) begin
                idx = i * 4 + k;
                if (idx < q_data.size()) begin
                    total++;
                    if ({q_data[idx], q_last[idx], q_strb[idx]} !== {d[k*32 +: 32], k == 3, 4'hF}) begin
                        bad++; $display("FAIL rand_beat%0d_%0d: got %h/%b/%h want %h/%b/f",
                                        i, k, q_data[idx], q_last[idx], q_strb[idx], d[k*32 +: 32], k == 3);
                    end
                end
            end
        end
    endtask

    task automatic test_bresp();
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL bresp_initial: got %b want 0", err_o); end
        set_line(0, 32'h4000_0000, {$urandom, $urandom, $urandom, $urandom}, 0, 4, 0, 2, 2'b10);
        run_lines(1);
        total++;
        if (tmo !== 1'b0 || extra_done !== 0) begin bad++; $display("FAIL bresp_done: got %0d want 1", n_done); end
        total++;
        if (err_o !== ERR_EN) begin bad++; $display("FAIL bresp_err: got %b want %b", err_o, ERR_EN); end
        set_line(0, 32'h4000_0010, {$urandom, $urandom, $urandom, $urandom}, 0, 4, 0, 0, 2'b00);
        run_lines(1);
        total++;
        if (err_o !== ERR_EN) begin bad++; $display("FAIL bresp_sticky: got %b want %b", err_o, ERR_EN); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL bresp_reset_clear: got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_stall();
        test_w_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_bresp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wline_master.md
AXI_WLINE_MASTER -- requirements
Module: axi_wline_master

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h1, the fixed AWID on every write burst.
REQ-002 SHALL have: clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have: wen_i  input  1  write-buffer request, a valid line is pending.
REQ-005 SHALL have: waddr_i  input  32  line address; bits [3:0] are ignored and forced to 0.
REQ-006 SHALL have: wdata_i  input  128  line data; word k is bits [32k+31:32k].
REQ-007 SHALL have: done_o  output  1  one-cycle pulse when the line is committed; drives the buffer's AXI_valid_i.
REQ-008 SHALL have: busy_o  output  1  high in any state other than IDLE.
REQ-009 SHALL have: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1 (all outputs); awready 1 (input).
REQ-010 SHALL have: wdata 32, wstrb 4, wlast 1, wvalid 1 (all outputs); wready 1 (input).
REQ-011 SHALL have: bid 4, bresp 2, bvalid 1 (all inputs); bready 1 (output).
REQ-012 SHALL have: err_o  output  1  sticky write-response error (see Configuration).

Function
REQ-013 SHALL use a state machine with states IDLE, AW, W, B, DONE.
REQ-014 IDLE: if wen_i=1, SHALL latch {waddr_i[31:4],4'b0} and wdata_i into internal registers and go to AW; otherwise it SHALL stay in IDLE.
REQ-015 The latched line SHALL be frozen until the next IDLE acceptance; input changes during a burst SHALL have no effect.
REQ-016 AW: awvalid=1, awaddr=latched address, awid=AXI_ID, awlen=3, awsize=3'b010, awburst=2'b01 (INCR); these SHALL hold stable until awvalid&awready, then go to W.
REQ-017 W SHALL NOT assert before the AW handshake has completed.
REQ-018 W: a 2-bit beat counter SHALL start at 0.
 - wdata = word[beat]; wstrb=4'hF; wvalid=1.
 - wlast=1 only when beat==3.
 - On wvalid&wready the counter SHALL increment; on the beat-3 handshake go to B.
REQ-019 wready low SHALL stall the current beat with wdata and wlast held unchanged.
REQ-020 B: bready=1; on bvalid go to DONE. Any bid SHALL be accepted.
REQ-021 DONE: done_o=1 for exactly this one cycle, then unconditionally go to IDLE; wen_i SHALL be ignored in DONE.
REQ-022 Minimum occupancy per line SHALL be 7 cycles with zero-wait slaves: AW 1, W 4, B 1, DONE 1.
REQ-023 A new acceptance SHALL occur at the earliest in the cycle after DONE. This lets the buffer clear its entry on the done_o edge before wen_i is sampled again.
REQ-024 All AXI valid/ready outputs SHALL be registered or state-decoded; none SHALL combinationally depend on awready, wready or bvalid.

Reset
REQ-025 When rst=0 at a clock edge, the block SHALL go to IDLE and clear the beat counter and err_o.
REQ-026 In reset, all outputs SHALL be 0, including awvalid, wvalid, wlast, bready, done_o and busy_o.
REQ-027 Reset asserted mid-burst SHALL abandon the burst without a done_o pulse. Re-synchronising the slave is the system's responsibility.

Configuration
REQ-028 Macro AXI_WLINE_BRESP_CHECK_EN SHALL select bresp error checking.
REQ-029 With the macro defined: a B handshake with bresp!=2'b00 SHALL set err_o=1. err_o SHALL stay 1 until reset. done_o SHALL still pulse.
REQ-030 Without the macro: err_o SHALL be constant 0 and bresp SHALL be unused.

Verification
REQ-031 Zero-wait slave; wen_i=1, waddr_i=32'h1000_0004, wdata_i=128'h44444444_33333333_22222222_11111111.
 - Required: awaddr=32'h1000_0000, awlen=3.
 - Beats 11111111, 22222222, 33333333, 44444444; wlast on the 4th.
 - done_o pulses 7 cycles after acceptance.
REQ-032 awready held low for 5 cycles -> awvalid stays 1 with a stable address; wvalid stays 0 until the AW handshake.
REQ-033 wready low for 3 cycles at beat 2 -> wdata stays 33333333 and the beat counter does not advance; the total burst is exactly 4 handshakes.
REQ-034 wen_i held high continuously with back-to-back lines A and B -> exactly one done_o per line; B is accepted in the cycle after A's DONE.
REQ-035 rst=0 during beat 1 -> the next cycle shows all outputs 0 and no done_o; a subsequent request completes normally.
REQ-036 With AXI_WLINE_BRESP_CHECK_EN, bresp=2'b10 -> err_o=1 sticky and done_o pulses; without the macro, err_o=0.
